// File: rtl/x_trim_pkg.sv
// Shared types for the x_trim context scheduler: context record, FSM states, tuser bit map.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package x_trim_pkg;

    // One crop/scale/reverse context as written by the register file (35 bits).
    typedef struct packed {
        logic        crop_en;
        logic [12:0] x_start;
        logic [12:0] x_size;
        logic [3:0]  x_scale;
        logic        x_reverse;
        logic [2:0]  csc;
    } x_ctx_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ARMED  = 2'd2,
        ACTIVE = 2'd3
    } sched_state_t;

    // Bit positions inside the snooped AXI-stream tuser.
    localparam int TUSER_SOF = 0;
    localparam int TUSER_EOF = 1;
    localparam int TUSER_SOL = 2;
    localparam int TUSER_EOL = 3;

endpackage

// File: rtl/x_trim_ctx_fifo.sv
// Small show-ahead FIFO of x_ctx_t contexts with flush.
// Latency: push visible at head/level one cycle later; pop_dat is combinational from the head.
// Backpressure: none internally; caller must not push when full unless popping the same cycle.
//
// Ports: aclk/aclk_reset clock and async reset; flush empties the queue; push/push_dat write;
//        pop/pop_dat read head; level/full/empty occupancy.
module x_trim_ctx_fifo
    import x_trim_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     aclk,
    input  logic                     aclk_reset,
    input  logic                     flush,
    input  logic                     push,
    input  x_ctx_t                   push_dat,
    input  logic                     pop,
    output x_ctx_t                   pop_dat,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

    x_ctx_t      mem [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    always_ff @(posedge aclk or posedge aclk_reset) begin
        if (aclk_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge aclk) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    assign pop_dat = mem[rd_ptr[AW-1:0]];
    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);

endmodule

// File: rtl/x_trim_ctx_sched.sv
// Per-frame context scheduler: queues validated crop contexts and applies one per frame to x_trim.
// Latency: push->strobe 2 cycles from IDLE; EOF->next strobe 1 cycle.
// Backpressure: stream_en gates upstream until a context is loaded; bad/overflowing pushes are dropped and flagged.
//
// Ports: aclk/aclk_reset clock and async reset; aclk_ctx_* context push; aclk_abort flush;
//        aclk_mon_* snooped x_trim input handshake; aclk_stream_en/aclk_grab_queue_en flow gates;
//        aclk_load_context ping-pong strobe; aclk_x_*/aclk_csc applied context;
//        aclk_q_level, aclk_frame_cnt, aclk_err status.
module x_trim_ctx_sched
    import x_trim_pkg::*;
#(
    parameter int CTX_DEPTH  = 2,
    parameter int MAX_X_SIZE = 8192,
    parameter int CNT_W      = 16
) (
    input  logic                          aclk,
    input  logic                          aclk_reset,
    input  logic                          aclk_ctx_wr,
    input  logic                          aclk_ctx_crop_en,
    input  logic [12:0]                   aclk_ctx_x_start,
    input  logic [12:0]                   aclk_ctx_x_size,
    input  logic [3:0]                    aclk_ctx_x_scale,
    input  logic                          aclk_ctx_x_reverse,
    input  logic [2:0]                    aclk_ctx_csc,
    input  logic                          aclk_abort,
    input  logic                          aclk_mon_tvalid,
    input  logic                          aclk_mon_tready,
    input  logic [3:0]                    aclk_mon_tuser,
    input  logic                          aclk_mon_tlast,
    output logic                          aclk_stream_en,
    output logic                          aclk_grab_queue_en,
    output logic [1:0]                    aclk_load_context,
    output logic                          aclk_x_crop_en,
    output logic [12:0]                   aclk_x_start,
    output logic [12:0]                   aclk_x_size,
    output logic [3:0]                    aclk_x_scale,
    output logic                          aclk_x_reverse,
    output logic [2:0]                    aclk_csc,
    output logic [$clog2(CTX_DEPTH):0]    aclk_q_level,
    output logic [CNT_W-1:0]              aclk_frame_cnt,
    output logic [2:0]                    aclk_err
);
    localparam logic [13:0] MAX_END = 14'(MAX_X_SIZE);

    sched_state_t state;
    logic         pp_idx;
    x_ctx_t       applied;
    x_ctx_t       in_ctx;
    x_ctx_t       head_ctx;
    x_ctx_t       load_ctx;

    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_push;
    logic         fifo_pop;

    logic         beat;
    logic         sof;
    logic         eof;
    logic [13:0]  ctx_end;
    logic         ctx_ok;
    logic         push_req;
    logic         frame_done;
    logic         load_now;
    logic         unused_mon;

    assign in_ctx = {aclk_ctx_crop_en, aclk_ctx_x_start, aclk_ctx_x_size,
                     aclk_ctx_x_scale, aclk_ctx_x_reverse, aclk_ctx_csc};

    assign beat = aclk_mon_tvalid & aclk_mon_tready;
    assign sof  = beat & aclk_mon_tuser[TUSER_SOF];
    assign eof  = beat & aclk_mon_tlast & aclk_mon_tuser[TUSER_EOF];

    // Line markers are not needed for frame tracking.
    assign unused_mon = &{1'b0, aclk_mon_tuser[TUSER_SOL], aclk_mon_tuser[TUSER_EOL]};

    // 14-bit sum so start+size can never wrap past the range check.
    assign ctx_end  = {1'b0, aclk_ctx_x_start} + {1'b0, aclk_ctx_x_size};
    assign ctx_ok   = (aclk_ctx_x_size != '0) && (ctx_end <= MAX_END);
    assign push_req = aclk_ctx_wr & ctx_ok & ~aclk_abort;

    // A single-beat frame (SOF+EOF while ARMED) completes just like an EOF in ACTIVE.
    assign frame_done = ((state == ACTIVE) & eof) | ((state == ARMED) & sof & eof);

    // IDLE only looks at the registered queue; an EOF also sees a same-cycle push.
    assign load_now = ~aclk_abort &
                      (((state == IDLE) & ~fifo_empty) |
                       (frame_done & (~fifo_empty | push_req)));

    // With an empty queue a load can only come from a same-cycle push at EOF:
    // that context bypasses the FIFO and is applied directly.
    assign fifo_pop  = load_now & ~fifo_empty;
    assign fifo_push = push_req & (~fifo_full | fifo_pop) & ~(load_now & fifo_empty);
    assign load_ctx  = fifo_empty ? in_ctx : head_ctx;

    x_trim_ctx_fifo #(
        .DEPTH (CTX_DEPTH)
    ) u_fifo (
        .aclk       (aclk),
        .aclk_reset (aclk_reset),
        .flush      (aclk_abort),
        .push       (fifo_push),
        .push_dat   (in_ctx),
        .pop        (fifo_pop),
        .pop_dat    (head_ctx),
        .level      (aclk_q_level),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_ff @(posedge aclk or posedge aclk_reset) begin
        if (aclk_reset) begin
            state             <= IDLE;
            pp_idx            <= 1'b0;
            applied           <= '0;
            aclk_load_context <= 2'b00;
            aclk_frame_cnt    <= '0;
            aclk_err          <= 3'b000;
        end else begin
            aclk_load_context <= 2'b00;

            if (aclk_abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE:    if (load_now) state <= LOAD;
                    LOAD:    state <= ARMED;
                    ARMED:   if (frame_done) state <= load_now ? LOAD : IDLE;
                             else if (sof)   state <= ACTIVE;
                    ACTIVE:  if (frame_done) state <= load_now ? LOAD : IDLE;
                    default: state <= IDLE;
                endcase
            end

            // Fields and strobe land together on the first LOAD cycle.
            if (load_now) begin
                applied           <= load_ctx;
                aclk_load_context <= pp_idx ? 2'b10 : 2'b01;
                pp_idx            <= ~pp_idx;
            end

            if (frame_done && !aclk_abort) aclk_frame_cnt <= aclk_frame_cnt + CNT_W'(1);

            aclk_err <= aclk_err | {
                (sof & (state == IDLE)),
                (aclk_ctx_wr & ~ctx_ok & ~aclk_abort),
                (push_req & fifo_full & ~fifo_pop)
            };
        end
    end

    assign aclk_stream_en     = (state == ARMED) || (state == ACTIVE);
    assign aclk_grab_queue_en = aclk_stream_en;

    assign aclk_x_crop_en = applied.crop_en;
    assign aclk_x_start   = applied.x_start;
    assign aclk_x_size    = applied.x_size;
    assign aclk_x_scale   = applied.x_scale;
    assign aclk_x_reverse = applied.x_reverse;
    assign aclk_csc       = applied.csc;

endmodule

// File: doc/x_trim_ctx_sched.md
Name: x_trim_ctx_sched

Overview:
Per-frame context scheduler for the x_trim horizontal crop/scale/reverse datapath, in the aclk domain.
- Accepts crop contexts from the register file into a small FIFO and validates each one against the line width.
- Applies one context per frame at frame boundaries, driving x_trim's aclk_x_* configuration and aclk_load_context strobe.
- Snoops the x_trim input AXI-stream handshake to track SOF/EOF, and gates upstream flow until a context is loaded.

Parameters:
CTX_DEPTH, 2, number of queued contexts (power of 2, ≥2).
MAX_X_SIZE, 8192, maximum line width in pixels; used for range checks.
CNT_W, 16, width of frame counters.

Ports:
aclk  in  1  clock
aclk_reset  in  1  async active-high reset
aclk_ctx_wr  in  1  push one context (single-cycle strobe)
aclk_ctx_crop_en  in  1  context: crop enable
aclk_ctx_x_start  in  13  context: ROI start pixel
aclk_ctx_x_size  in  13  context: ROI size in pixels
aclk_ctx_x_scale  in  4  context: subsample factor minus 1
aclk_ctx_x_reverse  in  1  context: reverse scan
aclk_ctx_csc  in  3  context: colour space code
aclk_abort  in  1  flush queue, return to IDLE
aclk_mon_tvalid  in  1  snooped x_trim input tvalid
aclk_mon_tready  in  1  snooped x_trim input tready
aclk_mon_tuser  in  4  snooped tuser: [0]=SOF, [1]=EOF, [2]=SOL, [3]=EOL
aclk_mon_tlast  in  1  snooped tlast
aclk_stream_en  out  1  upstream flow enable (ANDed into source tvalid/tready)
aclk_grab_queue_en  out  1  to x_trim
aclk_load_context  out  2  to x_trim, one-cycle one-hot strobe
aclk_x_crop_en  out  1  applied context field
aclk_x_start  out  13  applied context field
aclk_x_size  out  13  applied context field
aclk_x_scale  out  4  applied context field
aclk_x_reverse  out  1  applied context field
aclk_csc  out  3  applied context field
aclk_q_level  out  $clog2(CTX_DEPTH)+1  FIFO occupancy
aclk_frame_cnt  out  CNT_W  completed frames (wraps)
aclk_err  out  3  sticky: [0] queue overflow, [1] invalid context, [2] SOF with no context; cleared only by reset

Behaviour:
- Reset values: all outputs 0; state IDLE; queue empty; ping-pong index 0.
- Beat definition: beat = mon_tvalid & mon_tready. SOF = beat & tuser[0]. EOF = beat & tlast & tuser[1].
- Context validation on push: valid iff x_size≠0 and (x_start + x_size) ≤ MAX_X_SIZE. The sum is computed 14-bit, no wrap.
  - Invalid push: discarded, err[1] set.
  - Valid push while full (with no pop that cycle): discarded, err[0] set.
  - Push and pop in the same cycle with queue full: legal; the push is accepted.
- IDLE: stream_en=0, grab_queue_en=0.
  - If queue non-empty → LOAD.
  - SOF while in IDLE: sets err[2]; state stays IDLE.
- LOAD (exactly 1 cycle):
  - Pop queue head; register its fields onto aclk_x_*/aclk_csc (updated the same cycle the strobe asserts).
  - aclk_load_context = 2'b01 if ping-pong index is 0, else 2'b10; then toggle the index.
  - → ARMED.
- ARMED: stream_en=1, grab_queue_en=1.
  - SOF → ACTIVE.
  - A beat without tuser[0] is ignored; stay ARMED.
- ACTIVE: stream_en=1, grab_queue_en=1.
  - EOF: frame_cnt++ (mod 2^CNT_W); → LOAD if the queue is non-empty after any same-cycle push, else IDLE.
  - A single-beat frame (SOF and EOF on the same beat, seen in ARMED): counts as a complete frame; go directly to the EOF transition.
- Applied context fields hold their value between LOAD cycles; they never change inside a frame.
- Latency:
  - Push into empty queue while IDLE → load strobe 2 cycles later (push registered, then LOAD).
  - EOF → next strobe 1 cycle later.
- aclk_abort (any state): queue flushed, state → IDLE, stream_en drops the next cycle.
  - Applied fields and frame_cnt are held; no strobe.
  - A push in the abort cycle is dropped without setting an error.
- Reset mid-frame: immediate return to reset values; no strobe.

Decomposition:
- Package x_trim_pkg holds:
  - typedef struct packed x_ctx_t {crop_en, x_start[12:0], x_size[12:0], x_scale[3:0], x_reverse, csc[2:0]} (35 bits);
  - enum sched_state_t {IDLE, LOAD, ARMED, ACTIVE};
  - localparams for tuser bit indices (SOF=0, EOF=1, SOL=2, EOL=3).
- One sub-module: x_trim_ctx_fifo, a synchronous FIFO of x_ctx_t with CTX_DEPTH entries, push/pop/level/full/empty, and async active-high reset.

Test Plan:
1. Reset, push {crop_en=1, start=0, size=128, scale=0, rev=0}, then send a 4-row frame of 32 beats/row → load_context=01 at 2 cycles after push; x_size=128; frame_cnt=1; back to IDLE; stream_en=0.
2. Push 2 contexts (size 128, then start=8 size=64 rev=1), send 2 frames → strobes 01 then 10; the second context is applied exactly 1 cycle after the first frame's EOF; fields are stable throughout each frame.
3. Push 3 contexts with CTX_DEPTH=2 and no frames running → 1st popped to LOAD, 2nd and 3rd queued, q_level=2, err=0; a 4th push sets err[0]=1 and q_level stays 2.
4. Push start=8000 size=256 → rejected, err[1]=1, q_level=0; push size=0 → rejected.
5. Send SOF with the queue empty → err[2]=1, state stays IDLE, stream_en=0, frame_cnt unchanged.
6. Assert abort mid-frame with 1 context queued → state IDLE, q_level=0, frame_cnt unchanged; then assert reset mid-frame → all outputs 0.
